// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_arbiter_pkg : shared constants and round-robin select helper  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package rom_arbiter_pkg;

   localparam int c_max_req = 8;

   function automatic int ptr_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Rotated priority: the first set bit at or after ptr (mod n) wins.
   function automatic logic [c_max_req-1:0] rr_select(
      input logic [c_max_req-1:0] req,
      input int                   ptr,
      input int                   n
   );
      logic [c_max_req-1:0] gnt;
      logic                 found;
      logic [2:0]           idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < c_max_req; i++) begin
         idx = 3'((ptr + i) % n);
         if ((i < n) && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_arbiter_if : requester bus and ROM port of the ROM arbiter    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
interface rom_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
);
   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
   logic [NUM_REQ-1:0]            o_gnt;
   logic [NUM_REQ-1:0]            o_rvalid;
   logic [NUM_REQ*DATA_WIDTH-1:0] o_rdata;
   logic [ADDR_WIDTH-1:0]         o_rom_addr;
   logic [DATA_WIDTH-1:0]         i_rom_data;

   modport slave (
      input  i_req, i_addr, i_rom_data,
      output o_gnt, o_rvalid, o_rdata, o_rom_addr
   );

   modport master (
      output i_req, i_addr, i_rom_data,
      input  o_gnt, o_rvalid, o_rdata, o_rom_addr
   );
endinterface
`default_nettype wire

// File: rtl/rom_arbiter_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant with registered ptr  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module rr_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int c_ptr_w = ptr_width(NUM_REQ)
) (
   input  wire logic               clk_i,
   input  wire logic               rst_ni,
   input  wire logic [NUM_REQ-1:0] req_i,
   output logic      [NUM_REQ-1:0] gnt_o,
   output logic      [c_ptr_w-1:0] idx_o,
   output logic                    valid_o
);

   logic [c_ptr_w-1:0]   ptr_q;
   logic [c_ptr_w-1:0]   ptr_d;
   logic [c_max_req-1:0] w_sel;
   logic                 w_unused_sel;

   always_comb begin
      w_sel = rr_select(c_max_req'(req_i), int'(ptr_q), NUM_REQ);
   end

   // Bits above NUM_REQ are never set by rr_select.
   assign w_unused_sel = ^w_sel;
   assign gnt_o        = w_sel[NUM_REQ-1:0];
   assign valid_o      = |gnt_o;

   always_comb begin
      idx_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_o[k]) begin
            idx_o = c_ptr_w'(k);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (valid_o) begin
         ptr_d = (idx_o == c_ptr_w'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rom_arbiter : round-robin sharing of one 1-cycle-latency ROM      |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input wire logic     i_clk,
   input wire logic     i_rst_n,
   rom_arbiter_if.slave bus_if
);

   localparam int c_ptr_w = ptr_width(NUM_REQ);

   logic [NUM_REQ-1:0]    w_gnt;
   logic [c_ptr_w-1:0]    w_idx;
   logic                  w_any;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic [ADDR_WIDTH-1:0] last_addr_q;
   logic [ADDR_WIDTH-1:0] last_addr_d;
   logic [NUM_REQ-1:0]    rvalid_q;
   logic [NUM_REQ-1:0]    rvalid_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .req_i   (bus_if.i_req),
      .gnt_o   (w_gnt),
      .idx_o   (w_idx),
      .valid_o (w_any)
   );

   always_comb begin
      w_gnt_addr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_idx == c_ptr_w'(k)) begin
            w_gnt_addr = bus_if.i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Idle cycles replay the last address so the ROM address bus stays quiet.
   always_comb begin
      last_addr_d = w_any ? w_gnt_addr : last_addr_q;
      rvalid_d    = w_gnt;
   end

   assign bus_if.o_gnt      = w_gnt;
   assign bus_if.o_rom_addr = last_addr_d;
   assign bus_if.o_rvalid   = rvalid_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_addr_q <= '0;
         rvalid_q    <= '0;
      end else begin
         last_addr_q <= last_addr_d;
         rvalid_q    <= rvalid_d;
      end
   end

   generate
      for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
         logic [DATA_WIDTH-1:0] hold_q;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               hold_q <= '0;
            end else if (rvalid_q[k]) begin
               hold_q <= bus_if.i_rom_data;
            end
         end

         // The response cycle bypasses the hold register.
         assign bus_if.o_rdata[k*DATA_WIDTH +: DATA_WIDTH] =
            rvalid_q[k] ? bus_if.i_rom_data : hold_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rom_arbiter : directed self-checking bench for rom_arbiter     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_rom_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [15:0] mem [0:1023];

   rom_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(16)) bus2 ();
   rom_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(16)) bus3 ();

   rom_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(16)) u_dut2 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus_if  (bus2)
   );

   rom_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(10), .DATA_WIDTH(16)) u_dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus_if  (bus3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus2.i_rom_data <= mem[bus2.o_rom_addr];
   always @(posedge clk) bus3.i_rom_data <= mem[bus3.o_rom_addr];

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      bus2.i_req  = '0;
      bus2.i_addr = '0;
      bus3.i_req  = '0;
      bus3.i_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus2.o_gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt c%0d: got %b want 00", c, bus2.o_gnt);
         end
         n_checks++;
         if (bus2.o_rvalid !== 2'b00) begin
            n_fail++; $display("FAIL reset_rvalid c%0d: got %b want 00", c, bus2.o_rvalid);
         end
         n_checks++;
         if (bus2.o_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata c%0d: got %h want 0", c, bus2.o_rdata);
         end
         n_checks++;
         if (bus2.o_rom_addr !== 10'h000) begin
            n_fail++; $display("FAIL reset_rom_addr c%0d: got %h want 000", c, bus2.o_rom_addr);
         end
      end
   endtask

   task automatic test_single;
      next_cycle();
      bus2.i_req  = 2'b10;
      bus2.i_addr = {10'h005, 10'h000};
      @(negedge clk);
      n_checks++;
      if (bus2.o_gnt !== 2'b10) begin
         n_fail++; $display("FAIL single_gnt: got %b want 10", bus2.o_gnt);
      end
      n_checks++;
      if (bus2.o_rom_addr !== 10'h005) begin
         n_fail++; $display("FAIL single_rom_addr: got %h want 005", bus2.o_rom_addr);
      end
      next_cycle();
      bus2.i_req = 2'b00;
      @(negedge clk);
      n_checks++;
      if (bus2.o_rvalid !== 2'b10) begin
         n_fail++; $display("FAIL single_rvalid: got %b want 10", bus2.o_rvalid);
      end
      n_checks++;
      if (bus2.o_rdata[31:16] !== 16'hBEEF) begin
         n_fail++; $display("FAIL single_rdata: got %h want beef", bus2.o_rdata[31:16]);
      end
      n_checks++;
      if (bus2.o_rom_addr !== 10'h005) begin
         n_fail++; $display("FAIL single_addr_held: got %h want 005", bus2.o_rom_addr);
      end
      repeat (4) next_cycle();
      @(negedge clk);
      n_checks++;
      if (bus2.o_rdata[31:16] !== 16'hBEEF || bus2.o_rvalid !== 2'b00) begin
         n_fail++; $display("FAIL single_hold: got %h/%b want beef/00",
                            bus2.o_rdata[31:16], bus2.o_rvalid);
      end
   endtask

   task automatic test_alternate;
      int         cnt0 = 0;
      int         cnt1 = 0;
      int         prev = 0;
      int         cur;
      logic [1:0] exp_g;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         bus2.i_req  = 2'b11;
         bus2.i_addr = {10'h002, 10'h001};
         @(negedge clk);
         cur   = c % 2;
         exp_g = 2'b01 << cur;
         n_checks++;
         if (bus2.o_gnt !== exp_g) begin
            n_fail++; $display("FAIL alt_gnt c%0d: got %b want %b", c, bus2.o_gnt, exp_g);
         end
         n_checks++;
         if (bus2.o_rom_addr !== 10'(cur + 1)) begin
            n_fail++; $display("FAIL alt_rom_addr c%0d: got %h want %0d", c, bus2.o_rom_addr, cur + 1);
         end
         if (c > 0) begin
            n_checks++;
            if (bus2.o_rvalid !== (2'b01 << prev)) begin
               n_fail++; $display("FAIL alt_rvalid c%0d: got %b want port %0d", c, bus2.o_rvalid, prev);
            end
            n_checks++;
            if (bus2.o_rdata[prev*16 +: 16] !== 16'(16'h1001 + prev)) begin
               n_fail++; $display("FAIL alt_rdata c%0d: got %h want %h", c,
                                  bus2.o_rdata[prev*16 +: 16], 16'(16'h1001 + prev));
            end
         end
         cnt0 += int'(bus2.o_gnt[0]);
         cnt1 += int'(bus2.o_gnt[1]);
         prev  = cur;
      end
      next_cycle();
      bus2.i_req = 2'b00;
      @(negedge clk);
      n_checks++;
      if (bus2.o_rvalid !== 2'b10 || bus2.o_rdata !== {16'h1002, 16'h1001}) begin
         n_fail++; $display("FAIL alt_last: got %b/%h want 10/10021001", bus2.o_rvalid, bus2.o_rdata);
      end
      n_checks++;
      if (cnt0 != 4 || cnt1 != 4) begin
         n_fail++; $display("FAIL alt_fairness: got %0d/%0d want 4/4", cnt0, cnt1);
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] addr_tab [3] = '{10'h010, 10'h011, 10'h012};
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         if (c < 3) begin
            bus2.i_req  = 2'b01;
            bus2.i_addr = {10'h000, addr_tab[c]};
         end else begin
            bus2.i_req  = 2'b00;
         end
         @(negedge clk);
         n_checks++;
         if (bus2.o_gnt !== ((c < 3) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL b2b_gnt c%0d: got %b", c, bus2.o_gnt);
         end
         if (c < 3) begin
            n_checks++;
            if (bus2.o_rom_addr !== addr_tab[c]) begin
               n_fail++; $display("FAIL b2b_rom_addr c%0d: got %h want %h", c, bus2.o_rom_addr, addr_tab[c]);
            end
         end
         n_checks++;
         if (bus2.o_rvalid !== ((c >= 1 && c <= 3) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL b2b_rvalid c%0d: got %b", c, bus2.o_rvalid);
         end
         if (c >= 1) begin
            n_checks++;
            if (bus2.o_rdata[15:0] !== 16'(16'h100F + ((c > 3) ? 3 : c))) begin
               n_fail++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, bus2.o_rdata[15:0],
                                  16'(16'h100F + ((c > 3) ? 3 : c)));
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      next_cycle();
      bus2.i_req  = 2'b11;
      bus2.i_addr = {10'h002, 10'h001};
      @(negedge clk);
      n_checks++;
      if (bus2.o_gnt !== 2'b10) begin
         n_fail++; $display("FAIL rst_pre_gnt: got %b want 10", bus2.o_gnt);
      end
      next_cycle();
      bus2.i_req = 2'b00;
      #1;
      n_checks++;
      if (bus2.o_rvalid !== 2'b10) begin
         n_fail++; $display("FAIL rst_pre_rvalid: got %b want 10", bus2.o_rvalid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus2.o_rvalid !== 2'b00 || bus2.o_rdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_async: got %b/%h want 00/0", bus2.o_rvalid, bus2.o_rdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      bus2.i_req = 2'b11;
      @(negedge clk);
      n_checks++;
      if (bus2.o_gnt !== 2'b01 || bus2.o_rom_addr !== 10'h001) begin
         n_fail++; $display("FAIL rst_ptr_tie: got %b/%h want 01/001", bus2.o_gnt, bus2.o_rom_addr);
      end
      next_cycle();
      bus2.i_req = 2'b00;
   endtask

   task automatic test_three;
      int         idx_tab [8] = '{0, 1, 2, 0, 2, 0, 2, 0};
      logic [2:0] exp_g;
      int         prev = 0;
      bus3.i_addr = {10'h022, 10'h021, 10'h020};
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         bus3.i_req = (c < 4) ? 3'b111 : 3'b101;
         @(negedge clk);
         exp_g = 3'b001 << idx_tab[c];
         n_checks++;
         if (bus3.o_gnt !== exp_g) begin
            n_fail++; $display("FAIL three_gnt c%0d: got %b want %b", c, bus3.o_gnt, exp_g);
         end
         n_checks++;
         if (bus3.o_rom_addr !== 10'(10'h020 + idx_tab[c])) begin
            n_fail++; $display("FAIL three_rom_addr c%0d: got %h", c, bus3.o_rom_addr);
         end
         if (c > 0) begin
            n_checks++;
            if (bus3.o_rvalid !== (3'b001 << prev) ||
                bus3.o_rdata[prev*16 +: 16] !== 16'(16'h1020 + prev)) begin
               n_fail++; $display("FAIL three_resp c%0d: got %b/%h want port %0d data %h", c,
                                  bus3.o_rvalid, bus3.o_rdata[prev*16 +: 16], prev,
                                  16'(16'h1020 + prev));
            end
         end
         prev = idx_tab[c];
      end
      next_cycle();
      bus3.i_req = 3'b000;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'(16'h1000 + i);
      mem[5] = 16'hBEEF;
      test_reset();
      test_single();
      test_alternate();
      test_back_to_back();
      test_reset_mid();
      test_three();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, time %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
